// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. BCD digits are snapshotted once per scan frame so a
// frame never mixes old and new counts; anodes, segments and decimal point
// are all active-low and registered.
// Optional feature macro: LEADING_ZERO_BLANK_EN (leading-zero blanking).
module seven_seg_scan #(
  parameter int DIV   = 50000,
  parameter int DIV_W = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] D0,
  input  logic [3:0] D1,
  input  logic [3:0] D2,
  input  logic [3:0] D3,
  input  logic [3:0] DP_MASK,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       DP,
  output logic       FRAME
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] prescaler;
  logic [1:0]       idx;
  logic [3:0][3:0]  snap;
  logic [3:0]       snap_dp;
  logic             tick;
  logic             frame_load;
  logic [3:0]       blank;
  logic [3:0]       cur_digit;
  logic [6:0]       cur_seg;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD values show a dash.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign tick       = (prescaler == LAST);
  assign frame_load = tick && (idx == 2'd3);
  assign cur_digit  = snap[idx];
  assign cur_seg    = decode(cur_digit);

  // Prescaler: counts 0..DIV-1 and wraps, producing one tick per digit slot.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + DIV_W'(1);
    end
  end

  // Digit index: steps through the four digits, one per tick, wrapping 3->0.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx <= 2'd0;
    end else if (tick) begin
      idx <= idx + 2'd1;
    end
  end

  // Snapshot: captured only at the end of the last digit slot so every frame
  // shows one consistent set of digits.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      snap    <= '0;
      snap_dp <= 4'b0000;
    end else if (frame_load) begin
      snap    <= {D3, D2, D1, D0};
      snap_dp <= DP_MASK;
    end
  end

  // Blanking mask: a digit is blanked only when it and every more significant
  // digit of the snapshot are zero; the ones digit is always shown.
  always_comb begin
    blank = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    blank[3] = (snap[3] == 4'd0);
    blank[2] = blank[3] && (snap[2] == 4'd0);
    blank[1] = blank[2] && (snap[1] == 4'd0);
`else
    blank = 4'b0000;
`endif
  end

  // Output stage: registered pins, one stage behind idx and the snapshot.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      AN    <= 4'hF;
      SEG   <= 7'h7F;
      DP    <= 1'b1;
      FRAME <= 1'b0;
    end else begin
      AN    <= ~(4'b0001 << idx);
      SEG   <= blank[idx] ? 7'h7F : cur_seg;
      DP    <= ~snap_dp[idx];
      FRAME <= frame_load;
    end
  end

endmodule
